// File: rtl/rib_itcm_arbiter_if.sv
// RIB command/response bundle: the master drives the command and ready, and the
// slave answers with grant, response valid and read data.
interface rib_itcm_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   addr;
  logic                wrcs;
  logic [DATA_W/8-1:0] mask;
  logic [DATA_W-1:0]   wdata;
  logic                req;
  logic                gnt;
  logic [DATA_W-1:0]   rdata;
  logic                rsp;
  logic                rdy;

  modport master (
    output addr, wrcs, mask, wdata, req, rdy,
    input  gnt, rdata, rsp
  );

  modport slave (
    input  addr, wrcs, mask, wdata, req, rdy,
    output gnt, rdata, rsp
  );
endinterface

// File: rtl/rib_itcm_arbiter.sv
// Two-master RIB arbiter for the shared ITCM port: grants one command per cycle and
// steers each in-order slave response back to its issuer through an owner FIFO.
module rib_itcm_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int OUTSTANDING = 2,
  parameter int RR_EN       = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  rib_itcm_arbiter_if.slave  m0_if,
  rib_itcm_arbiter_if.slave  m1_if,
  rib_itcm_arbiter_if.master s_if,
  output logic               o_err
);
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING) + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

  logic             owner_q [OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_prio_q, rr_prio_d;
  logic             err_q, err_d;

  logic win_s, full_s, empty_s, head_s;
  logic s_req_s, push_s, pop_s, s_rdy_s, rsp_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // rr_prio_q names the master favoured on a tie; with no request the M0 fields pass through
  always_comb begin
    win_s = 1'b0;
    case ({m1_if.req, m0_if.req})
      2'b11:   win_s = (RR_EN != 0) ? rr_prio_q : 1'b1;
      2'b10:   win_s = 1'b1;
      default: win_s = 1'b0;
    endcase
  end

  assign full_s   = (cnt_q == CNT_FULL);
  assign empty_s  = (cnt_q == {CNT_W{1'b0}});
  assign head_s   = owner_q[rd_ptr_q];
  assign s_req_s  = (m0_if.req | m1_if.req) & ~full_s & ~i_rst;
  assign push_s   = s_req_s & s_if.gnt;
  assign rsp_ok_s = s_if.rsp & ~empty_s & ~i_rst;
  assign s_rdy_s  = ~empty_s & ~i_rst & (head_s ? m1_if.rdy : m0_if.rdy);
  assign pop_s    = s_if.rsp & s_rdy_s;

  assign s_if.req   = s_req_s;
  assign s_if.addr  = win_s ? m1_if.addr  : m0_if.addr;
  assign s_if.wrcs  = win_s ? m1_if.wrcs  : m0_if.wrcs;
  assign s_if.mask  = win_s ? m1_if.mask  : m0_if.mask;
  assign s_if.wdata = win_s ? m1_if.wdata : m0_if.wdata;
  assign s_if.rdy   = s_rdy_s;

  assign m0_if.gnt   = push_s & ~win_s;
  assign m1_if.gnt   = push_s & win_s;
  assign m0_if.rsp   = rsp_ok_s & ~head_s;
  assign m1_if.rsp   = rsp_ok_s & head_s;
  assign m0_if.rdata = s_if.rdata;
  assign m1_if.rdata = s_if.rdata;

  assign o_err = err_q;

  // Owner FIFO bookkeeping, tie-break pointer and the sticky orphan-response flag
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rr_prio_d = rr_prio_q;
    err_d     = err_q;
    if (push_s) begin
      wr_ptr_d  = ptr_inc(wr_ptr_q);
      rr_prio_d = ~win_s;
    end else begin
      wr_ptr_d  = wr_ptr_q;
      rr_prio_d = rr_prio_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (s_if.rsp && empty_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Control state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      rr_prio_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rr_prio_q <= rr_prio_d;
      err_q     <= err_d;
    end
  end

  // Owner storage needs no reset: entries are only read while the count covers them
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      owner_q[wr_ptr_q] <= win_s;
    end
  end
endmodule
